// File: rtl/led_shift_sequencer.sv
// Command-driven 8-LED rotating pattern sequencer with its own shift timebase.
// Commands arrive over valid/ready; runs end by step count, STOP, or never.
module led_shift_sequencer #(
  parameter int unsigned CLK_FREQ       = 25_000_000,
  parameter int unsigned DEFAULT_PERIOD = CLK_FREQ / 4,
  parameter logic [7:0]  INIT_PATTERN   = 8'h1F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic [7:0]  leds,
  output logic        busy,
  output logic        done,
  output logic        cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_LOAD       = 2'd0;
  localparam logic [1:0] OP_SET_PERIOD = 2'd1;
  localparam logic [1:0] OP_RUN        = 2'd2;
  localparam logic [1:0] OP_STOP       = 2'd3;

  // A zero period would never let the tick counter match, so clamp to 1.
  localparam logic [31:0] RESET_PERIOD = (DEFAULT_PERIOD == 0) ? 32'd1 : 32'(DEFAULT_PERIOD);

  state_t      state, state_nxt;
  logic [31:0] period;
  logic [31:0] tick_cnt;
  logic [7:0]  step_cnt;
  logic [7:0]  steps_target;
  logic        dir;
  logic        accept;
  logic        tick_wrap;
  logic [7:0]  step_nxt;
  logic        err_nxt;

  function automatic logic [7:0] rotate(input logic [7:0] pat, input logic right);
    return right ? {pat[0], pat[7:1]} : {pat[6:0], pat[7]};
  endfunction

  assign cmd_ready = (state != S_DONE);
  assign accept    = cmd_valid & (state != S_DONE);
  assign tick_wrap = (tick_cnt == period - 32'd1);
  assign step_nxt  = step_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && cmd_op == OP_RUN) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (accept && cmd_op != OP_STOP) err_nxt = 1'b1;
        if (accept && cmd_op == OP_STOP) state_nxt = S_DONE;
        if (tick_wrap && steps_target != 8'd0 && step_nxt == steps_target) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: configuration latches in IDLE, pattern rotation in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      leds         <= INIT_PATTERN;
      period       <= RESET_PERIOD;
      tick_cnt     <= 32'd0;
      step_cnt     <= 8'd0;
      steps_target <= 8'd0;
      dir          <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      cmd_err <= err_nxt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_LOAD:       leds <= cmd_data[7:0];
              OP_SET_PERIOD: period <= (cmd_data == 32'd0) ? 32'd1 : cmd_data;
              OP_RUN: begin
                dir          <= cmd_data[0];
                steps_target <= cmd_data[15:8];
                tick_cnt     <= 32'd0;
                step_cnt     <= 8'd0;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (tick_wrap) begin
            leds     <= rotate(leds, dir);
            tick_cnt <= 32'd0;
            step_cnt <= step_nxt;
          end else begin
            tick_cnt <= tick_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_shift_sequencer.sv
// Directed bench for led_shift_sequencer with CLK_FREQ=8 (default period 2).
// Each scenario task drives commands and compares outputs 1ns after the edge.
module tb_led_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic [7:0]  leds;
  logic        busy;
  logic        done;
  logic        cmd_err;

  int pass_cnt = 0;
  int total    = 0;

  localparam logic [1:0] OP_LOAD = 2'd0, OP_SETP = 2'd1, OP_RUN = 2'd2, OP_STOP = 2'd3;

  led_shift_sequencer #(
    .CLK_FREQ(8),
    .DEFAULT_PERIOD(2),
    .INIT_PATTERN(8'h1F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .leds(leds),
    .busy(busy),
    .done(done),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    total++; if (leds !== 8'h1F) $display("FAIL reset_leds: got %h want 1f", leds); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else pass_cnt++;
    total++; if (cmd_err !== 1'b0) $display("FAIL reset_err: got %b want 0", cmd_err); else pass_cnt++;
  endtask

  task automatic test_run_left_steps();
    logic [7:0] exp_l [4] = '{8'h3E, 8'h7C, 8'hF8, 8'hF1};
    logic [7:0] want;
    send(OP_RUN, 32'h0000_0400);
    total++; if (busy !== 1'b1) $display("FAIL left_busy_start: got %b want 1", busy); else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      want = (k >= 2) ? exp_l[k/2 - 1] : 8'h1F;
      total++; if (leds !== want) $display("FAIL left_leds_e%0d: got %h want %h", k, leds, want); else pass_cnt++;
      total++; if (busy !== (k < 8)) $display("FAIL left_busy_e%0d: got %b want %b", k, busy, (k < 8)); else pass_cnt++;
      total++; if (done !== (k == 8)) $display("FAIL left_done_e%0d: got %b want %b", k, done, (k == 8)); else pass_cnt++;
    end
    total++; if (cmd_ready !== 1'b0) $display("FAIL left_ready_in_done: got %b want 0", cmd_ready); else pass_cnt++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL left_done_after: got %b want 0", done); else pass_cnt++;
    total++; if (cmd_ready !== 1'b1) $display("FAIL left_ready_idle: got %b want 1", cmd_ready); else pass_cnt++;
    total++; if (leds !== 8'hF1) $display("FAIL left_leds_hold: got %h want f1", leds); else pass_cnt++;
  endtask

  task automatic test_run_right_steps();
    int n_done = 0;
    logic [7:0] want;
    send(OP_LOAD, 32'h0000_0081);
    total++; if (leds !== 8'h81) $display("FAIL right_load: got %h want 81", leds); else pass_cnt++;
    send(OP_RUN, 32'h0000_0201);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (done === 1'b1) n_done++;
      want = (k < 2) ? 8'h81 : (k < 4) ? 8'hC0 : 8'h60;
      total++; if (leds !== want) $display("FAIL right_leds_e%0d: got %h want %h", k, leds, want); else pass_cnt++;
    end
    total++; if (n_done != 1) $display("FAIL right_done_pulses: got %0d want 1", n_done); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL right_busy_end: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_continuous_stop();
    logic [7:0] exp_c [4] = '{8'h3E, 8'h7C, 8'hF8, 8'hF1};
    send(OP_LOAD, 32'h0000_001F);
    send(OP_SETP, 32'd0);
    send(OP_RUN, 32'h0000_0000);
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++; if (leds !== exp_c[k-1]) $display("FAIL cont_leds_e%0d: got %h want %h", k, leds, exp_c[k-1]); else pass_cnt++;
    end
    // STOP lands on the fifth rotation edge.
    send(OP_STOP, 32'd0);
    total++; if (leds !== 8'hE3) $display("FAIL cont_stop_leds: got %h want e3", leds); else pass_cnt++;
    total++; if (done !== 1'b1) $display("FAIL cont_stop_done: got %b want 1", done); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL cont_stop_busy: got %b want 0", busy); else pass_cnt++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL cont_done_once: got %b want 0", done); else pass_cnt++;
    total++; if (leds !== 8'hE3) $display("FAIL cont_hold: got %h want e3", leds); else pass_cnt++;
  endtask

  task automatic test_err_in_run();
    logic [1:0]  ops  [3] = '{OP_LOAD, OP_SETP, OP_RUN};
    logic [31:0] dats [3] = '{32'hAA, 32'd7, 32'd0};
    logic [7:0]  exp_e [4] = '{8'hE3, 8'hC7, 8'hC7, 8'h8F};
    send(OP_SETP, 32'd2);
    send(OP_RUN, 32'h0000_0000);
    for (int k = 1; k <= 4; k++) begin
      if (k <= 3) begin
        cmd_valid = 1'b1; cmd_op = ops[k-1]; cmd_data = dats[k-1];
      end
      tick();
      cmd_valid = 1'b0;
      total++; if (cmd_err !== (k <= 3)) $display("FAIL err_pulse_e%0d: got %b want %b", k, cmd_err, (k <= 3)); else pass_cnt++;
      total++; if (leds !== exp_e[k-1]) $display("FAIL err_leds_e%0d: got %h want %h", k, leds, exp_e[k-1]); else pass_cnt++;
      total++; if (busy !== 1'b1) $display("FAIL err_busy_e%0d: got %b want 1", k, busy); else pass_cnt++;
    end
    send(OP_STOP, 32'd0);
    total++; if (done !== 1'b1) $display("FAIL err_stop_done: got %b want 1", done); else pass_cnt++;
    total++; if (leds !== 8'h8F) $display("FAIL err_stop_leds: got %h want 8f", leds); else pass_cnt++;
    tick();
    send(OP_STOP, 32'd0);
    total++; if (cmd_err !== 1'b0) $display("FAIL idle_stop_err: got %b want 0", cmd_err); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL idle_stop_done: got %b want 0", done); else pass_cnt++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL idle_stop_done2: got %b want 0", done); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL idle_stop_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    send(OP_SETP, 32'd3);
    send(OP_RUN, 32'h0000_0000);
    for (int k = 1; k <= 9; k++) tick();
    total++; if (leds !== 8'h7C) $display("FAIL mid_leds_3rot: got %h want 7c", leds); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (leds !== 8'h1F) $display("FAIL mid_rst_leds: got %h want 1f", leds); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else pass_cnt++;
    total++; if (cmd_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", cmd_ready); else pass_cnt++;
    send(OP_RUN, 32'h0000_0100);
    tick();
    total++; if (leds !== 8'h1F) $display("FAIL mid_run1_e1: got %h want 1f", leds); else pass_cnt++;
    tick();
    total++; if (leds !== 8'h3E) $display("FAIL mid_run1_e2: got %h want 3e", leds); else pass_cnt++;
    total++; if (done !== 1'b1) $display("FAIL mid_run1_done: got %b want 1", done); else pass_cnt++;
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL mid_run1_idle: got done=%b busy=%b want 0/0", done, busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_run_left_steps();
    test_run_right_steps();
    test_continuous_stop();
    test_err_in_run();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/led_shift_sequencer.md
Name: led_shift_sequencer

Overview:
- Command-driven controller that sequences the board's 8-LED rotating pattern.
- Takes configuration and run commands over a valid/ready port: pattern load, shift period, direction, step count, start and stop.
- Owns the shift-rate timebase.
- Sits between a host/command source (UART decoder or test FSM) and the LED pins, replacing the free-running LED shifter wherever software control of the pattern is needed.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- DEFAULT_PERIOD, CLK_FREQ/4, shift period in clock cycles loaded at reset.
- INIT_PATTERN, 8'h1F, LED pattern loaded at reset.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command this cycle.
- cmd_op  input  2  0=LOAD, 1=SET_PERIOD, 2=RUN, 3=STOP.
- cmd_data  input  32  command operand.
- leds  output  8  LED pattern (registered).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a run ends.
- cmd_err  output  1  one-cycle pulse when an accepted command is illegal in the current state.

Behaviour:
- Reset values, applied on any clk edge with rst=1, including mid-run:
  - State and outputs: state=IDLE, leds=INIT_PATTERN, busy=0, done=0, cmd_err=0, cmd_ready=1.
  - Internal registers: period=DEFAULT_PERIOD, tick_cnt=0, step_cnt=0, steps_target=0, dir=0 (left).
- States: IDLE, RUN, DONE.
- Handshake:
  - A command is accepted on an edge where cmd_valid & cmd_ready.
  - cmd_ready=1 in IDLE and RUN, 0 in DONE.
  - All effects are visible the cycle after acceptance.
- LOAD:
  - IDLE: leds <= cmd_data[7:0].
  - RUN: ignored, cmd_err=1 for one cycle.
- SET_PERIOD:
  - IDLE: period <= cmd_data; a value of 0 is stored as 1.
  - RUN: ignored, cmd_err=1.
- RUN:
  - IDLE: dir <= cmd_data[0] (0=rotate left, 1=rotate right), steps_target <= cmd_data[15:8], tick_cnt <= 0, step_cnt <= 0, state <= RUN.
  - steps_target=0 means continuous operation.
  - RUN command while already in RUN: ignored, cmd_err=1.
- STOP:
  - RUN: state <= DONE, leds hold their current value.
  - IDLE: no-op, no cmd_err.
- In RUN, every edge:
  - If tick_cnt==period-1: rotate leds one position in dir (left: {leds[6:0],leds[7]}; right: {leds[0],leds[7:1]}), tick_cnt <= 0, step_cnt++.
  - Otherwise tick_cnt++.
  - First rotation lands exactly period edges after the accepting edge; subsequent rotations every period edges.
- Run termination:
  - If steps_target!=0 and the rotation makes step_cnt==steps_target, state <= DONE on that same edge.
  - step_cnt is 8 bits; in continuous mode it wraps freely and has no effect.
- Simultaneous STOP and rotation on the same edge: the rotation is applied and state <= DONE; exactly one done pulse results.
- DONE: lasts exactly one cycle with done=1, busy=0, cmd_ready=0, then IDLE. leds hold the final pattern.
- busy=1 exactly while state==RUN.
- Counters:
  - tick_cnt and period are 32-bit unsigned.
  - Changing period requires IDLE, so tick_cnt can never exceed period-1.

Test Plan:
1. Reset with CLK_FREQ=8 -> leds=0x1F, busy=0, done=0, cmd_ready=1; period internally 2.
2. RUN with cmd_data=0x0400 (left, N=4) -> leds 0x3E, 0x7C, 0xF8, 0xF1 at 2, 4, 6, 8 edges after accept; busy high through the 8th edge; done=1 for the following cycle; cmd_ready=0 in that cycle; then IDLE with leds=0xF1.
3. LOAD 0x81, then RUN with cmd_data=0x0201 (right, N=2) -> leds 0xC0 then 0x60 at 2-cycle spacing, single done pulse, leds hold 0x60.
4. SET_PERIOD 0, then RUN with cmd_data=0x0000 (continuous left) from leds=0x1F -> leds rotate every edge (0x3E, 0x7C, ...); STOP after 5 rotations -> leds hold 0xE3, done pulse one cycle, busy low.
5. During a continuous run, issue LOAD 0xAA, SET_PERIOD 7 and RUN -> each gives a one-cycle cmd_err; leds sequence and timing unchanged; STOP in IDLE -> no cmd_err, no done.
6. Assert rst mid-run after 3 rotations -> next edge leds=0x1F, busy=0, state IDLE; a new RUN with N=1 rotates at 2 edges, confirming period restored to DEFAULT_PERIOD.
